// File: rtl/video_timing_gen.sv
// Raster timing generator: full-frame pixel counters plus sync, data-enable,
// line/frame start pulses and HDMI period markers, all registered together.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CORDW    = 12
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [1:0]       mode
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
    $error("video_timing_gen: timing parameters must all be non-zero");
  end
  // The preamble and guard band must sit wholly inside the back porch.
  if (H_BP < 10) begin : g_err_hbp
    $error("video_timing_gen: H_BP must be at least 10");
  end
  if (CORDW < 2 || CORDW > 30) begin : g_err_cordw
    $error("video_timing_gen: CORDW out of range");
  end
  if (H_TOTAL > (2 ** CORDW) - 1 || V_TOTAL > (2 ** CORDW) - 1) begin : g_err_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CORDW bits");
  end

  localparam logic [CORDW-1:0] C_H_LAST     = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] C_V_LAST     = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] C_H_ACTIVE   = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] C_V_ACTIVE   = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] C_HS_BEG     = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] C_HS_END     = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] C_VS_BEG     = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] C_VS_END     = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] C_GUARD_BEG  = CORDW'(H_TOTAL - 2);
  localparam logic [CORDW-1:0] C_PREAM_BEG  = CORDW'(H_TOTAL - 10);
  localparam logic [CORDW-1:0] C_V_PRE_LIM  = CORDW'(V_ACTIVE - 1);

  logic [CORDW-1:0] r_sx;
  logic [CORDW-1:0] r_sy;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_line_start;
  logic             r_frame_start;
  logic [1:0]       r_mode;

  logic             w_x_wrap;
  logic             w_y_wrap;
  logic [CORDW-1:0] w_nx;
  logic [CORDW-1:0] w_ny;
  logic             w_n_de;
  logic             w_n_hs;
  logic             w_n_vs;
  logic             w_n_pre;
  logic [1:0]       w_n_mode;

  // Every output is decoded from the next position so it lands in the same
  // register stage as the counters and never lags them.
  always_comb begin
    w_x_wrap = (r_sx == C_H_LAST);
    w_y_wrap = (r_sy == C_V_LAST);
    w_nx     = w_x_wrap ? '0 : r_sx + CORDW'(1);
    w_ny     = r_sy;
    if (w_x_wrap) begin
      w_ny = w_y_wrap ? '0 : r_sy + CORDW'(1);
    end
    w_n_de  = (w_nx < C_H_ACTIVE) && (w_ny < C_V_ACTIVE);
    w_n_hs  = ((w_nx >= C_HS_BEG) && (w_nx < C_HS_END)) ? H_POL : ~H_POL;
    w_n_vs  = ((w_ny >= C_VS_BEG) && (w_ny < C_VS_END)) ? V_POL : ~V_POL;
    // Pre-active: the following line (modulo the frame) is a visible line.
    w_n_pre = (w_ny == C_V_LAST) || (w_ny < C_V_PRE_LIM);
    w_n_mode = 2'd0;
    if (w_n_de) begin
      w_n_mode = 2'd3;
    end else if (w_n_pre && (w_nx >= C_GUARD_BEG)) begin
      w_n_mode = 2'd2;
    end else if (w_n_pre && (w_nx >= C_PREAM_BEG)) begin
      w_n_mode = 2'd1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst) begin
      r_sx          <= C_H_LAST;
      r_sy          <= C_V_LAST;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_mode        <= 2'd0;
    end else if (en) begin
      r_sx          <= w_nx;
      r_sy          <= w_ny;
      r_hsync       <= w_n_hs;
      r_vsync       <= w_n_vs;
      r_de          <= w_n_de;
      r_line_start  <= (w_nx == '0);
      r_frame_start <= (w_nx == '0) && (w_ny == '0);
      r_mode        <= w_n_mode;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign sx          = r_sx;
  assign sy          = r_sy;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign mode        = r_mode;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three parameterisations checked every cycle
// against a linear-position frame model, plus directed boundary steps.
module tb_video_timing_gen;

  localparam int CW = 12;
  localparam int B_HA = 20, B_HF = 3, B_HS = 4, B_HB = 10;
  localparam int B_VA = 12, B_VF = 2, B_VS = 2, B_VB = 3;

  typedef struct { int ha, hf, hs, hb, va, vf, vs, vb; bit hp, vp; } cfg_t;
  typedef struct { int sx, sy; bit hs, vs, de, ls, fs; int mode; } vo_t;
  typedef struct { logic [CW-1:0] sx, sy; logic hs, vs, de, ls, fs; logic [1:0] mode; } ob_t;

  // clock / reset block
  logic clk_pix = 1'b0;
  logic [2:0] rst_n = '0;
  logic [2:0] en_v  = '0;
  always #5 clk_pix = ~clk_pix;

  logic [CW-1:0] sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
  logic hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
  logic hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic hsync_c, vsync_c, de_c, line_start_c, frame_start_c;
  logic [1:0] mode_a, mode_b, mode_c;

  video_timing_gen #(.CORDW(CW)) u_dut_a (
    .clk_pix(clk_pix), .rst(rst_n[0]), .en(en_v[0]), .sx(sx_a), .sy(sy_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .line_start(line_start_a),
    .frame_start(frame_start_a), .mode(mode_a));

  video_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(1'b1), .V_POL(1'b0), .CORDW(CW)
  ) u_dut_b (
    .clk_pix(clk_pix), .rst(rst_n[1]), .en(en_v[1]), .sx(sx_b), .sy(sy_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .line_start(line_start_b),
    .frame_start(frame_start_b), .mode(mode_b));

  video_timing_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720), .V_FP(5), .V_SYNC(5), .V_BP(20),
    .H_POL(1'b1), .V_POL(1'b1), .CORDW(CW)
  ) u_dut_c (
    .clk_pix(clk_pix), .rst(rst_n[2]), .en(en_v[2]), .sx(sx_c), .sy(sy_c),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .line_start(line_start_c),
    .frame_start(frame_start_c), .mode(mode_c));

  cfg_t cfg [3];
  int   pos [3];
  vo_t  mdl [3];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // reference model: frame position is a single linear index
  function automatic int htot(cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic vo_t decode(cfg_t c, int p);
    vo_t r;
    int x, y, ht, vt;
    bit pre;
    ht = htot(c);
    vt = vtot(c);
    x = p % ht;
    y = p / ht;
    r.sx = x;
    r.sy = y;
    r.de = (x < c.ha) && (y < c.va);
    r.hs = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
    r.vs = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : !c.vp;
    pre = ((y + 1) % vt) < c.va;
    if (r.de) r.mode = 3;
    else if (pre && x >= ht - 2) r.mode = 2;
    else if (pre && x >= ht - 10) r.mode = 1;
    else r.mode = 0;
    r.ls = (x == 0);
    r.fs = (p == 0);
    return r;
  endfunction

  function automatic vo_t reset_vo(cfg_t c);
    vo_t r;
    r.sx = htot(c) - 1;
    r.sy = vtot(c) - 1;
    r.hs = !c.hp;
    r.vs = !c.vp;
    r.de = 1'b0;
    r.ls = 1'b0;
    r.fs = 1'b0;
    r.mode = 0;
    return r;
  endfunction

  function automatic ob_t observe(int k);
    ob_t o;
    case (k)
      0: begin
        o.sx = sx_a; o.sy = sy_a; o.hs = hsync_a; o.vs = vsync_a; o.de = de_a;
        o.ls = line_start_a; o.fs = frame_start_a; o.mode = mode_a;
      end
      1: begin
        o.sx = sx_b; o.sy = sy_b; o.hs = hsync_b; o.vs = vsync_b; o.de = de_b;
        o.ls = line_start_b; o.fs = frame_start_b; o.mode = mode_b;
      end
      default: begin
        o.sx = sx_c; o.sy = sy_c; o.hs = hsync_c; o.vs = vsync_c; o.de = de_c;
        o.ls = line_start_c; o.fs = frame_start_c; o.mode = mode_c;
      end
    endcase
    return o;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int tot;
    tot = htot(cfg[k]) * vtot(cfg[k]);
    if (!rst_n[k]) begin
      pos[k] = tot - 1;
      mdl[k] = reset_vo(cfg[k]);
    end else if (en_v[k]) begin
      pos[k] = (pos[k] + 1) % tot;
      mdl[k] = decode(cfg[k], pos[k]);
    end else begin
      mdl[k].ls = 1'b0;
      mdl[k].fs = 1'b0;
    end
  endtask

  task automatic check_inst(input int k);
    ob_t o;
    vo_t m;
    string nm;
    o = observe(k);
    m = mdl[k];
    nm = (k == 0) ? "a" : (k == 1) ? "b" : "c";
    cmp({nm, " sx"}, 32'(o.sx), m.sx);
    cmp({nm, " sy"}, 32'(o.sy), m.sy);
    cmp({nm, " hsync"}, 32'(o.hs), 32'(m.hs));
    cmp({nm, " vsync"}, 32'(o.vs), 32'(m.vs));
    cmp({nm, " de"}, 32'(o.de), 32'(m.de));
    cmp({nm, " line_start"}, 32'(o.ls), 32'(m.ls));
    cmp({nm, " frame_start"}, 32'(o.fs), 32'(m.fs));
    cmp({nm, " mode"}, 32'(o.mode), m.mode);
  endtask

  // scoreboard: frame_start spacing of instance b measured in advances
  int  adv_b = 0;
  int  last_fs_b = 0;
  bit  have_fs_b = 1'b0;

  task automatic tick();
    if (!rst_n[1]) have_fs_b = 1'b0;
    else if (en_v[1]) adv_b++;
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk_pix);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) check_inst(k);
    if (frame_start_b) begin
      if (have_fs_b) cmp("b frame period", adv_b - last_fs_b, htot(cfg[1]) * vtot(cfg[1]));
      last_fs_b = adv_b;
      have_fs_b = 1'b1;
    end
  endtask

  // line statistics for instances a and c
  int last_ls_a = -1, de_cnt_a = 0, hs_lo0_a = 0, m1_0_a = 0, m2_0_a = 0;
  int hs_hi0_c = 0, first_hs_c = -1, max_sx_c = 0;

  task automatic mon_ac();
    if (line_start_a) begin
      if (last_ls_a >= 0) begin
        cmp("a line period", cyc - last_ls_a, 800);
        cmp("a de per line", de_cnt_a, 640);
      end
      last_ls_a = cyc;
      de_cnt_a = 0;
    end
    if (de_a) de_cnt_a++;
    if (sy_a == 0) begin
      if (!hsync_a) hs_lo0_a++;
      if (mode_a == 2'd1) m1_0_a++;
      if (mode_a == 2'd2) m2_0_a++;
    end
    if (sy_c == 0 && hsync_c) begin
      hs_hi0_c++;
      if (first_hs_c < 0) first_hs_c = int'(sx_c);
    end
    if (int'(sx_c) > max_sx_c) max_sx_c = int'(sx_c);
  endtask

  initial begin
    bit found;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b0};
    cfg[2] = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

    // reset held with random enables
    rst_n = '0;
    repeat (3) begin
      en_v = 3'($urandom_range(0, 7));
      tick();
    end
    cmp("a reset sx", 32'(sx_a), 799);
    cmp("a reset sy", 32'(sy_a), 524);
    cmp("a reset mode", 32'(mode_a), 0);
    cmp("a reset hsync", 32'(hsync_a), 1);
    cmp("c reset sx", 32'(sx_c), 1649);
    cmp("c reset sy", 32'(sy_c), 749);
    cmp("c reset hsync", 32'(hsync_c), 0);

    // first advance after release
    rst_n = 3'b111;
    en_v = 3'b101;
    en_v[1] = 1'($urandom_range(0, 1));
    tick();
    mon_ac();
    cmp("a first sx", 32'(sx_a), 0);
    cmp("a first sy", 32'(sy_a), 0);
    cmp("a first de", 32'(de_a), 1);
    cmp("a first mode", 32'(mode_a), 3);
    cmp("a first line_start", 32'(line_start_a), 1);
    cmp("a first frame_start", 32'(frame_start_a), 1);

    // free-run a and c to the end of line 10; b stalls randomly
    for (int i = 0; i < 9000 && pos[0] != 8799; i++) begin
      en_v[1] = 1'($urandom_range(0, 1));
      tick();
      mon_ac();
    end
    cmp("a reach sx", 32'(sx_a), 799);
    cmp("a reach sy", 32'(sy_a), 10);
    cmp("a line0 hsync low count", hs_lo0_a, 96);
    cmp("a line0 preamble count", m1_0_a, 8);
    cmp("a line0 guard count", m2_0_a, 2);
    cmp("c line0 hsync high count", hs_hi0_c, 40);
    cmp("c first hsync sx", first_hs_c, 1390);
    cmp("c max sx", max_sx_c, 1649);

    // stall a at the end of line 10, then one advance
    en_v[0] = 1'b0;
    repeat (2) begin
      tick();
      cmp("a stall sx", 32'(sx_a), 799);
      cmp("a stall sy", 32'(sy_a), 10);
      cmp("a stall line_start", 32'(line_start_a), 0);
    end
    en_v[0] = 1'b1;
    tick();
    cmp("a resume sx", 32'(sx_a), 0);
    cmp("a resume sy", 32'(sy_a), 11);
    cmp("a resume line_start", 32'(line_start_a), 1);
    tick();
    cmp("a pulse width", 32'(line_start_a), 0);

    // mid-frame reset of b at sx=15, sy=7; a and c also stall randomly
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en_v = 3'($urandom_range(0, 7));
      tick();
      if (pos[1] == 7 * 37 + 15) begin
        found = 1'b1;
        break;
      end
    end
    cmp("b reach target", 32'(found), 1);
    cmp("b target sx", 32'(sx_b), 15);
    cmp("b target sy", 32'(sy_b), 7);
    rst_n[1] = 1'b0;
    en_v[1] = 1'($urandom_range(0, 1));
    tick();
    cmp("b midreset sx", 32'(sx_b), 36);
    cmp("b midreset sy", 32'(sy_b), 18);
    cmp("b midreset de", 32'(de_b), 0);
    cmp("b midreset hsync", 32'(hsync_b), 0);
    cmp("b midreset mode", 32'(mode_b), 0);
    rst_n[1] = 1'b1;
    en_v[1] = 1'b1;
    tick();
    cmp("b restart sx", 32'(sx_b), 0);
    cmp("b restart sy", 32'(sy_b), 0);
    cmp("b restart mode", 32'(mode_b), 3);
    cmp("b restart frame_start", 32'(frame_start_b), 1);

    repeat (1600) begin
      en_v = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
